// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: field widths, opcodes,
// accumulator mux encodings and the control FSM state encoding.
package bip_pkg;

    localparam int PC_WIDTH      = 11;
    localparam int INSTR_WIDTH   = 16;
    localparam int OPCODE_WIDTH  = 5;
    localparam int OPERAND_WIDTH = 11;
    localparam int CNT_WIDTH     = 32;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = 5'd0;
    localparam logic [OPCODE_WIDTH-1:0] OP_STO  = 5'd1;
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 5'd2;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'd3;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'd4;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'd5;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'd6;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 5'd7;

    localparam logic [1:0] SEL_A_RAM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Decoded form of the current instruction, latched at the end of DECODE.
    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc_en;
        logic       wr_ram_en;
        logic       illegal;
    } ctrl_t;

    function automatic logic [OPCODE_WIDTH-1:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
        return instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    endfunction

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: maps a 5-bit opcode to datapath selectors,
// strobe enables and sequencing hints for the control FSM.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    output logic [1:0]              o_sel_a,
    output logic                    o_sel_b,
    output logic                    o_op,
    output logic                    o_is_mem,
    output logic                    o_wr_acc_en,
    output logic                    o_wr_ram_en,
    output logic                    o_is_hlt,
    output logic                    o_illegal
);

    always_comb begin
        o_sel_a     = SEL_A_RAM;
        o_sel_b     = 1'b0;
        o_op        = 1'b0;
        o_is_mem    = 1'b0;
        o_wr_acc_en = 1'b0;
        o_wr_ram_en = 1'b0;
        o_is_hlt    = 1'b0;
        o_illegal   = 1'b0;
        case (i_opcode)
            OP_HLT: o_is_hlt = 1'b1;
            OP_STO: o_wr_ram_en = 1'b1;
            OP_LD: begin
                o_sel_a     = SEL_A_RAM;
                o_is_mem    = 1'b1;
                o_wr_acc_en = 1'b1;
            end
            OP_LDI: begin
                o_sel_a     = SEL_A_IMM;
                o_wr_acc_en = 1'b1;
            end
            OP_ADD: begin
                o_sel_a     = SEL_A_ALU;
                o_is_mem    = 1'b1;
                o_wr_acc_en = 1'b1;
            end
            OP_ADDI: begin
                o_sel_a     = SEL_A_ALU;
                o_sel_b     = 1'b1;
                o_wr_acc_en = 1'b1;
            end
            OP_SUB: begin
                o_sel_a     = SEL_A_ALU;
                o_op        = 1'b1;
                o_is_mem    = 1'b1;
                o_wr_acc_en = 1'b1;
            end
            OP_SUBI: begin
                o_sel_a     = SEL_A_ALU;
                o_sel_b     = 1'b1;
                o_op        = 1'b1;
                o_wr_acc_en = 1'b1;
            end
            // Undefined opcodes run as a NOP and only raise the sticky flag.
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: PC, instruction register, multi-cycle sequencing FSM and
// executed-cycle counter driving the accumulator datapath and data RAM.
module bip_control
    import bip_pkg::*;
(
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [INSTR_WIDTH-1:0]   i_instr,
    output logic [PC_WIDTH-1:0]      o_pc,
    output logic [OPERAND_WIDTH-1:0] o_operand,
    output logic [1:0]               o_sel_a,
    output logic                     o_sel_b,
    output logic                     o_op,
    output logic                     o_rd_ram,
    output logic                     o_wr_ram,
    output logic                     o_wr_acc,
    output logic                     o_halt,
    output logic                     o_illegal,
    output logic [CNT_WIDTH-1:0]     o_cycle_count
);

    state_t                   state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [OPERAND_WIDTH-1:0] ir_operand_q, ir_operand_d;
    ctrl_t                    ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                     illegal_q, illegal_d;

    logic [1:0] dec_sel_a;
    logic       dec_sel_b;
    logic       dec_op;
    logic       dec_is_mem;
    logic       dec_wr_acc_en;
    logic       dec_wr_ram_en;
    logic       dec_is_hlt;
    logic       dec_illegal;

    // Decodes the ROM word directly; the result is captured with the IR.
    bip_decoder u_decoder (
        .i_opcode    (opcode_of(i_instr)),
        .o_sel_a     (dec_sel_a),
        .o_sel_b     (dec_sel_b),
        .o_op        (dec_op),
        .o_is_mem    (dec_is_mem),
        .o_wr_acc_en (dec_wr_acc_en),
        .o_wr_ram_en (dec_wr_ram_en),
        .o_is_hlt    (dec_is_hlt),
        .o_illegal   (dec_illegal)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            ir_operand_q <= '0;
            ctrl_q       <= '0;
            cnt_q        <= '0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_operand_q <= ir_operand_d;
            ctrl_q       <= ctrl_d;
            cnt_q        <= cnt_d;
            illegal_q    <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_operand_d = ir_operand_q;
        ctrl_d       = ctrl_q;
        cnt_d        = cnt_q;
        illegal_d    = illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_operand_d = i_instr[OPERAND_WIDTH-1:0];
                ctrl_d       = {dec_sel_a, dec_sel_b, dec_op,
                                dec_wr_acc_en, dec_wr_ram_en, dec_illegal};
                if (dec_is_hlt) begin
                    state_d = ST_HALT;
                end else if (dec_is_mem) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_MEM: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                pc_d    = pc_q + PC_WIDTH'(1);
                state_d = ST_FETCH;
                if (ctrl_q.illegal) begin
                    illegal_d = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counts only while an instruction is in flight; sticks at all-ones.
        if ((state_q == ST_FETCH || state_q == ST_DECODE ||
             state_q == ST_MEM   || state_q == ST_EXEC) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    assign o_pc          = pc_q;
    assign o_operand     = ir_operand_q;
    assign o_sel_a       = ctrl_q.sel_a;
    assign o_sel_b       = ctrl_q.sel_b;
    assign o_op          = ctrl_q.op;
    assign o_rd_ram      = (state_q == ST_MEM);
    assign o_wr_ram      = (state_q == ST_EXEC) && ctrl_q.wr_ram_en;
    assign o_wr_acc      = (state_q == ST_EXEC) && ctrl_q.wr_acc_en;
    assign o_halt        = (state_q == ST_HALT);
    assign o_illegal     = illegal_q;
    assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: a synchronous program ROM, per-opcode vector table,
// directed corner sequences and random programs against a program-walk model.
module tb_bip_control;

    typedef struct packed {
        logic [10:0] pc;
        logic [10:0] operand;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        op;
        logic        rd;
        logic        wr_ram;
        logic        wr_acc;
        logic        halt;
        logic        illegal;
        logic [31:0] cnt;
    } cyc_t;
    localparam int CYC_W = $bits(cyc_t);

    typedef struct {
        logic [15:0] instr;
        int          halt_idx;
        int          n_rd;
        int          n_acc;
        int          n_ram;
        logic [3:0]  sels;
        logic        ill;
    } vec_t;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_instr = 16'h0;
    logic [10:0] o_pc;
    logic [10:0] o_operand;
    logic [1:0]  o_sel_a;
    logic        o_sel_b;
    logic        o_op;
    logic        o_rd_ram;
    logic        o_wr_ram;
    logic        o_wr_acc;
    logic        o_halt;
    logic        o_illegal;
    logic [31:0] o_cycle_count;

    logic [15:0]      rom [2048];
    logic [3:0]       sel_tab [8];
    logic [CYC_W-1:0] exp_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;

    bip_control dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_instr       (i_instr),
        .o_pc          (o_pc),
        .o_operand     (o_operand),
        .o_sel_a       (o_sel_a),
        .o_sel_b       (o_sel_b),
        .o_op          (o_op),
        .o_rd_ram      (o_rd_ram),
        .o_wr_ram      (o_wr_ram),
        .o_wr_acc      (o_wr_acc),
        .o_halt        (o_halt),
        .o_illegal     (o_illegal),
        .o_cycle_count (o_cycle_count)
    );

    // Clock and synchronous-read program ROM.
    always #5 i_clock = ~i_clock;
    always @(posedge i_clock) i_instr <= rom[o_pc];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cyc_t cur();
        cyc_t c;
        c = {o_pc, o_operand, o_sel_a, o_sel_b, o_op, o_rd_ram, o_wr_ram,
             o_wr_acc, o_halt, o_illegal, o_cycle_count};
        return c;
    endfunction

    task automatic do_reset();
        i_start = 1'b0;
        @(negedge i_clock);
        #1 i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
    endtask

    // Returns at the negedge of the first FETCH cycle.
    task automatic start_run();
        @(negedge i_clock);
        i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int a = 0; a < 2048; a++) rom[a] = w;
    endtask

    // Reference: one expected output record per clock, built by walking the program.
    function automatic cyc_t mk(input logic [10:0] p, input logic [15:0] w,
                                input logic rd, input logic ram, input logic acc,
                                input logic hlt, input logic ill, input logic [31:0] c);
        cyc_t       e;
        logic [3:0] s;
        s = (w[15:11] < 5'd8) ? sel_tab[w[13:11]] : 4'd0;
        e.pc = p;       e.operand = w[10:0];
        e.sel_a = s[3:2]; e.sel_b = s[1]; e.op = s[0];
        e.rd = rd;      e.wr_ram = ram;  e.wr_acc = acc;
        e.halt = hlt;   e.illegal = ill; e.cnt = c;
        return e;
    endfunction

    task automatic build_trace(input int max_instr);
        logic [10:0] p = 11'd0;
        logic [15:0] r = 16'h0;
        logic [15:0] w;
        logic [31:0] c = 32'd0;
        logic        ill = 1'b0;
        int          oc;
        for (int k = 0; k < max_instr; k++) begin
            w  = rom[p];
            oc = int'(w[15:11]);
            for (int j = 0; j < 2; j++) begin
                exp_q.push_back(mk(p, r, 0, 0, 0, 0, ill, c));
                c++;
            end
            if (oc == 0) begin
                for (int j = 0; j < 3; j++) exp_q.push_back(mk(p, w, 0, 0, 0, 1, ill, c));
                return;
            end
            if (oc == 2 || oc == 4 || oc == 6) begin
                exp_q.push_back(mk(p, w, 1, 0, 0, 0, ill, c));
                c++;
            end
            exp_q.push_back(mk(p, w, 0, oc == 1, oc >= 2 && oc <= 7, 0, ill, c));
            c++;
            if (oc >= 8) ill = 1'b1;
            r = w;
            p = p + 11'd1;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          halt_idx = 12;
        int          n_rd = 0, n_acc = 0, n_ram = 0;
        logic [3:0]  sels = 4'd0;
        logic [10:0] opnd = 11'd0;
        fill_rom(16'h0000);
        rom[0] = v.instr;
        do_reset();
        start_run();
        for (int i = 0; i < 12; i++) begin
            if (o_halt && halt_idx == 12) halt_idx = i;
            n_rd  += int'(o_rd_ram);
            n_acc += int'(o_wr_acc);
            n_ram += int'(o_wr_ram);
            if (i == 2) begin
                sels = {o_sel_a, o_sel_b, o_op};
                opnd = o_operand;
            end
            @(negedge i_clock);
        end
        check($sformatf("vec%0d_halt_idx", idx), halt_idx, v.halt_idx);
        check($sformatf("vec%0d_rd_pulses", idx), n_rd, v.n_rd);
        check($sformatf("vec%0d_acc_pulses", idx), n_acc, v.n_acc);
        check($sformatf("vec%0d_ram_pulses", idx), n_ram, v.n_ram);
        check($sformatf("vec%0d_sels", idx), sels, v.sels);
        check($sformatf("vec%0d_operand", idx), opnd, v.instr[10:0]);
        check($sformatf("vec%0d_illegal", idx), o_illegal, v.ill);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        vec_t        vecs [10];
        int          n;
        int          strobes;
        int          halt_at;
        logic [10:0] sto_opnd;

        sel_tab[0] = 4'b0000; sel_tab[1] = 4'b0000; sel_tab[2] = 4'b0000; sel_tab[3] = 4'b0100;
        sel_tab[4] = 4'b1000; sel_tab[5] = 4'b1010; sel_tab[6] = 4'b1001; sel_tab[7] = 4'b1011;

        vecs[0] = '{16'h1805, 5, 0, 1, 0, 4'b0100, 1'b0};  // LDI 5
        vecs[1] = '{16'h2003, 6, 1, 1, 0, 4'b1000, 1'b0};  // ADD 3
        vecs[2] = '{16'h0000, 2, 0, 0, 0, 4'b0000, 1'b0};  // HLT
        vecs[3] = '{16'h0FFF, 5, 0, 0, 1, 4'b0000, 1'b0};  // STO 0x7FF
        vecs[4] = '{16'h1000, 6, 1, 1, 0, 4'b0000, 1'b0};  // LD 0
        vecs[5] = '{16'h2801, 5, 0, 1, 0, 4'b1010, 1'b0};  // ADDI 1
        vecs[6] = '{16'h3004, 6, 1, 1, 0, 4'b1001, 1'b0};  // SUB 4
        vecs[7] = '{16'h3802, 5, 0, 1, 0, 4'b1011, 1'b0};  // SUBI 2
        vecs[8] = '{16'hF800, 5, 0, 0, 0, 4'b0000, 1'b1};  // opcode 31
        vecs[9] = '{16'h4123, 5, 0, 0, 0, 4'b0000, 1'b1};  // opcode 8

        fill_rom(16'h0000);
        #2 i_reset = 1'b1;
        #1 check("reset_outputs", cur(), '0);
        @(negedge i_clock);
        i_reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Async reset mid-run clears everything; unit then idles until start.
        fill_rom(16'h2003);
        do_reset();
        start_run();
        repeat ($urandom_range(2, 9)) @(negedge i_clock);
        #1 i_reset = 1'b1;
        #1 check("midrun_reset_outputs", cur(), '0);
        @(negedge i_clock);
        i_reset = 1'b0;
        repeat (3) @(negedge i_clock);
        check("idle_no_progress", {o_pc, o_cycle_count}, '0);
        start_run();
        check("first_fetch_pc", o_pc, 11'd0);
        @(negedge i_clock);
        check("first_count_step", o_cycle_count, 32'd1);

        // LDI timing: strobe in third cycle, next FETCH three cycles after the first.
        fill_rom(16'h1805);
        do_reset();
        start_run();
        repeat (2) @(negedge i_clock);
        check("ldi_exec", {o_pc, o_operand, o_sel_a, o_wr_acc}, {11'd0, 11'd5, 2'd1, 1'b1});
        @(negedge i_clock);
        check("ldi_next_fetch", {o_pc, o_wr_acc}, {11'd1, 1'b0});

        // LDI, STO 0x7FF, HLT: counter stops at 8 and start is ignored.
        fill_rom(16'h0000);
        rom[0] = 16'h1805; rom[1] = 16'h0FFF; rom[2] = 16'h0000;
        do_reset();
        start_run();
        halt_at = 20; strobes = 0; sto_opnd = 11'd0;
        for (int i = 0; i < 20; i++) begin
            if (o_wr_ram) begin strobes++; sto_opnd = o_operand; end
            if (o_halt && halt_at == 20) halt_at = i;
            @(negedge i_clock);
        end
        check("hlt_reach_idx", halt_at, 8);
        check("sto_pulses", strobes, 1);
        check("sto_operand", sto_opnd, 11'h7FF);
        check("hlt_count", o_cycle_count, 32'd8);
        for (int i = 0; i < 3; i++) begin
            i_start = 1'b1;
            @(negedge i_clock);
            i_start = 1'b0;
            repeat (2) @(negedge i_clock);
        end
        check("hlt_frozen", {o_halt, o_pc, o_cycle_count}, {1'b1, 11'd2, 32'd8});

        // Reset asserted during an STO EXEC drops the write strobe immediately.
        fill_rom(16'h0000);
        rom[0] = 16'h0FFF;
        do_reset();
        start_run();
        n = 0;
        while (!o_wr_ram && n < 10) begin @(negedge i_clock); n++; end
        check("sto_exec_seen", o_wr_ram, 1'b1);
        #1 i_reset = 1'b1;
        #1 check("exec_reset_strobe", {o_wr_ram, o_pc, o_cycle_count}, '0);
        @(negedge i_clock);
        i_reset = 1'b0;
        repeat (3) @(negedge i_clock);
        check("exec_reset_idle", {o_pc, o_cycle_count, o_halt}, '0);

        // All-illegal ROM: no strobes, sticky flag, PC wraps and keeps going.
        fill_rom(16'hF800);
        do_reset();
        start_run();
        n = 0; strobes = 0;
        while (o_pc != 11'h7FF && n < 7000) begin
            strobes += int'(o_wr_acc | o_wr_ram | o_rd_ram);
            @(negedge i_clock);
            n++;
        end
        check("reach_pc_7ff", o_pc, 11'h7FF);
        n = 0;
        while (o_pc != 11'd0 && n < 10) begin
            strobes += int'(o_wr_acc | o_wr_ram | o_rd_ram);
            @(negedge i_clock);
            n++;
        end
        check("wrap_pc", o_pc, 11'd0);
        check("wrap_count", o_cycle_count, 32'd6144);
        repeat (3) @(negedge i_clock);
        check("after_wrap_pc", o_pc, 11'd1);
        check("illegal_no_strobes", strobes, 0);
        check("illegal_sticky", o_illegal, 1'b1);

        // Random programs ending in HLT, compared cycle by cycle with the model.
        for (int t = 0; t < 4; t++) begin
            int oc;
            fill_rom(16'h0000);
            for (int a = 0; a < 30; a++) begin
                oc = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 31) : $urandom_range(1, 7);
                rom[a] = {oc[4:0], 11'($urandom)};
            end
            rom[30] = {5'd0, 11'($urandom)};
            exp_q.delete();
            do_reset();
            build_trace(40);
            start_run();
            while (exp_q.size() > 0) begin
                check($sformatf("rand%0d_cycle", t), cur(), exp_q.pop_front());
                i_start = 1'($urandom_range(0, 1));
                @(negedge i_clock);
            end
            i_start = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
